// File: rtl/mem_arbiter.sv
// Serializes instruction-fetch and data accesses onto one single-ported RAM.
// Data has priority; a starvation counter forces a fetch grant after STARVE_MAX data grants.
module mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic              ihit,
    output logic [DATA_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic              dhit,
    output logic [DATA_W-1:0] dload,
    output logic              ram_ren,
    output logic              ram_wen,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_store,
    input  logic [DATA_W-1:0] ram_load,
    input  logic              ram_ready,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, IACC, DACC, RESP} state_t;

    localparam logic [3:0] SMAX = 4'(STARVE_MAX);

    state_t            state, state_nx;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] store_q;
    logic              wr_q;
    logic              gnt_i;
    logic [3:0]        starve_cnt;
    logic              dreq, data_win;

    assign dreq     = dREN | dWEN;
    assign data_win = dreq && !(iREN && starve_cnt == SMAX);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (data_win)  state_nx = DACC;
                else if (iREN) state_nx = IACC;
            end
            IACC, DACC: if (ram_ready) state_nx = RESP;
            RESP:       state_nx = IDLE;
            default:    state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            addr_q     <= '0;
            store_q    <= '0;
            wr_q       <= 1'b0;
            gnt_i      <= 1'b0;
            starve_cnt <= '0;
            iload      <= '0;
            dload      <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE) begin
                if (data_win) begin
                    addr_q     <= daddr;
                    store_q    <= dstore;
                    wr_q       <= dWEN;
                    gnt_i      <= 1'b0;
                    // only count data grants that actually made a fetch wait
                    starve_cnt <= !iREN ? 4'd0 : (starve_cnt == SMAX) ? SMAX : starve_cnt + 4'd1;
                end else if (iREN) begin
                    addr_q     <= iaddr;
                    store_q    <= dstore;
                    wr_q       <= 1'b0;
                    gnt_i      <= 1'b1;
                    starve_cnt <= '0;
                end
            end
            if (state == IACC && ram_ready)          iload <= ram_load;
            if (state == DACC && ram_ready && !wr_q) dload <= ram_load;
        end
    end

    assign ram_ren   = (state == IACC) || (state == DACC && !wr_q);
    assign ram_wen   = (state == DACC) && wr_q;
    assign ram_addr  = addr_q;
    assign ram_store = store_q;
    assign busy      = (state != IDLE);
    // hit is dropped if the requester withdrew before the response cycle
    assign ihit      = (state == RESP) && gnt_i && iREN;
    assign dhit      = (state == RESP) && !gnt_i && dreq;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a transaction-level model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_mem_arbiter;
    localparam int AW = 32, DW = 32, SM = 4;

    logic          CLK = 1'b0, RST = 1'b1;
    logic          iREN = 0, dREN = 0, dWEN = 0, ram_ready = 0;
    logic [AW-1:0] iaddr = '0, daddr = '0;
    logic [DW-1:0] dstore = '0, ram_load = '0;
    logic          ihit, dhit, ram_ren, ram_wen, busy;
    logic [DW-1:0] iload, dload, ram_store;
    logic [AW-1:0] ram_addr;

    int errors = 0, checks = 0;
    bit started = 0;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .ihit(ihit), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dhit(dhit), .dload(dload),
        .ram_ren(ram_ren), .ram_wen(ram_wen), .ram_addr(ram_addr),
        .ram_store(ram_store), .ram_load(ram_load), .ram_ready(ram_ready),
        .busy(busy)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Transaction model: who owns the RAM and whether the access or the reply is in flight
    int            m_owner = 0;   // 0 none, 1 fetch, 2 data
    int            m_phase = 0;   // 0 free, 1 access in flight, 2 reply cycle
    int            m_starve = 0;
    bit            m_wr = 0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_store = '0, m_iload = '0, m_dload = '0;
    string         glog = "";

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            m_owner = 0; m_phase = 0; m_starve = 0; m_wr = 0;
            m_addr = '0; m_store = '0; m_iload = '0; m_dload = '0;
        end else if (m_phase == 0) begin
            if ((dREN || dWEN) && !(iREN && m_starve >= SM)) begin
                m_owner = 2; m_wr = dWEN; m_addr = daddr; m_store = dstore; m_phase = 1;
                m_starve = iREN ? ((m_starve + 1 > SM) ? SM : m_starve + 1) : 0;
                glog = {glog, "D"};
            end else if (iREN) begin
                m_owner = 1; m_wr = 0; m_addr = iaddr; m_phase = 1; m_starve = 0;
                glog = {glog, "I"};
            end
        end else if (m_phase == 1) begin
            if (ram_ready) begin
                if (m_owner == 1) m_iload = ram_load;
                else if (!m_wr)   m_dload = ram_load;
                m_phase = 2;
            end
        end else begin
            m_phase = 0; m_owner = 0;
        end
    end

    always @(negedge CLK) begin
        if (started) begin
            chk("m_busy",  busy,    m_phase != 0);
            chk("m_ren",   ram_ren, m_phase == 1 && (m_owner == 1 || !m_wr));
            chk("m_wen",   ram_wen, m_phase == 1 && m_owner == 2 && m_wr);
            chk("m_ihit",  ihit,    m_phase == 2 && m_owner == 1 && iREN);
            chk("m_dhit",  dhit,    m_phase == 2 && m_owner == 2 && (dREN || dWEN));
            chk("m_iload", iload,   m_iload);
            chk("m_dload", dload,   m_dload);
            if (m_phase == 1) chk("m_addr", ram_addr, m_addr);
            if (m_phase == 1 && m_owner == 2 && m_wr) chk("m_store", ram_store, m_store);
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        repeat (2) tick();
        chk("rst_busy", busy, 0);
        chk("rst_ihit", ihit, 0);
        chk("rst_dhit", dhit, 0);
        chk("rst_iload", iload, 0);
        chk("rst_dload", dload, 0);
        chk("rst_ren", ram_ren, 0);
        RST = 0;
        started = 1;
        tick();

        // reset mid data write
        dWEN = 1; daddr = 32'h8; dstore = 32'h11;
        tick();
        chk("dacc_wen", ram_wen, 1);
        RST = 1;
        #1;
        chk("rst_async_wen", ram_wen, 0);
        chk("rst_async_busy", busy, 0);
        tick();
        RST = 0; dWEN = 0;
        tick();
        chk("post_rst_dhit", dhit, 0);
        chk("post_rst_dload", dload, 0);

        // single fetch, zero wait
        iREN = 1; iaddr = 32'h40; ram_load = 32'hDEADBEEF; ram_ready = 1;
        tick();
        chk("fetch_ren", ram_ren, 1);
        chk("fetch_addr", ram_addr, 32'h40);
        tick();
        chk("fetch_ihit", ihit, 1);
        chk("fetch_iload", iload, 32'hDEADBEEF);
        tick();
        iREN = 0; ram_ready = 0;
        tick();

        // data read with three wait cycles
        dREN = 1; daddr = 32'h100; ram_load = 32'h12345678;
        tick();
        repeat (3) tick();
        chk("wait_dhit_early", dhit, 0);
        ram_ready = 1;
        tick();
        chk("wait_dhit", dhit, 1);
        chk("wait_ihit", ihit, 0);
        chk("wait_dload", dload, 32'h12345678);
        tick();
        dREN = 0; ram_ready = 0;
        tick();

        // priority and starvation
        glog = "";
        iREN = 1; dREN = 1; ram_ready = 1; ram_load = 32'h0BADF00D; iaddr = 32'h44; daddr = 32'h104;
        repeat (28) tick();
        iREN = 0; dREN = 0;
        repeat (3) tick();
        checks++;
        if (glog != "DDDDIDDDDI") begin
            errors++;
            $display("FAIL starve_order: got %s expected DDDDIDDDDI", glog);
        end
        chk("starve_iload", iload, 32'h0BADF00D);

        // read+write together is a write
        dREN = 1; dWEN = 1; daddr = 32'h8; dstore = 32'hA5A5A5A5; ram_load = 32'hFFFFFFFF;
        tick();
        chk("rw_wen", ram_wen, 1);
        chk("rw_ren", ram_ren, 0);
        chk("rw_store", ram_store, 32'hA5A5A5A5);
        chk("rw_addr", ram_addr, 32'h8);
        tick();
        chk("rw_dhit", dhit, 1);
        chk("rw_dload", dload, 32'h0BADF00D);
        tick();
        dREN = 0; dWEN = 0; ram_ready = 0;
        tick();

        // fetch dropped mid-access, data waiting behind it
        iREN = 1; iaddr = 32'h80; ram_load = 32'hCAFEF00D;
        tick();
        iREN = 0; dREN = 1; daddr = 32'h200; ram_ready = 1;
        tick();
        chk("drop_ihit", ihit, 0);
        chk("drop_dhit", dhit, 0);
        chk("drop_iload", iload, 32'hCAFEF00D);
        tick();
        chk("drop_idle", busy, 0);
        tick();
        chk("drop_dgrant_ren", ram_ren, 1);
        chk("drop_dgrant_addr", ram_addr, 32'h200);
        ram_load = 32'h55;
        tick();
        chk("drop_dhit2", dhit, 1);
        chk("drop_dload", dload, 32'h55);
        tick();
        dREN = 0; ram_ready = 0;
        repeat (2) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
